// File: rtl/rvvi_al_pkg.sv
// Shared types and sizing helpers for the RVVI retransmit active list.
package rvvi_al_pkg;

  typedef enum logic {AL_IDLE, AL_REPLAY} al_state_t;

  function automatic int unsigned al_tag_width(input int unsigned log2d);
    return log2d + 1;
  endfunction

  function automatic int unsigned al_timer_width(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/rvvi_al_flops.sv
// Enabled flops with synchronous reset; flopenl adds a priority load port.
module flopenr #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  always_ff @(posedge i_clk) begin
    if (i_reset)   o_q <= '0;
    else if (i_en) o_q <= i_d;
  end
endmodule

module flopenl #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_val,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  always_ff @(posedge i_clk) begin
    if (i_reset)     o_q <= '0;
    else if (i_load) o_q <= i_val;
    else if (i_en)   o_q <= i_d;
  end
endmodule

// File: rtl/rvvi_al_replay_fsm.sv
// Replay controller: trigger detection, ack timer, replay pointer walk and registered output beat.
module rvvi_al_replay_fsm
  import rvvi_al_pkg::*;
#(
  parameter int unsigned ENTRIES_LOG2 = 3,
  parameter int unsigned WIDTH        = 792,
  parameter int unsigned TIMEOUT      = 4096,
  parameter int unsigned REPLAY_ALL   = 0
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [2**ENTRIES_LOG2-1:0] i_active,
  input  logic [ENTRIES_LOG2:0]     i_head,
  input  logic [ENTRIES_LOG2:0]     i_tail,
  input  logic                      i_tail_adv,
  input  logic                      i_empty,
  input  logic                      i_ack_acc,
  input  logic [ENTRIES_LOG2:0]     i_ack_tag,
  input  logic                      i_rep_ready,
  input  logic [WIDTH-1:0]          i_rd_data,
  output logic [ENTRIES_LOG2:0]     o_rd_ptr,
  output logic                      o_rep_valid,
  output logic [WIDTH-1:0]          o_rep_data,
  output logic [ENTRIES_LOG2:0]     o_rep_tag,
  output logic                      o_replaying
);
  localparam int unsigned L  = ENTRIES_LOG2;
  localparam int unsigned T  = al_tag_width(ENTRIES_LOG2);
  localparam int unsigned TW = al_timer_width(TIMEOUT);

  al_state_t       r_state, w_state_nx;
  logic [T-1:0]    r_rep_ptr, r_head_snap;
  logic [T-1:0]    w_lag, w_span, w_eff, w_eff_nx;
  logic [TW-1:0]   r_timer;
  logic            r_rep_valid;
  logic [WIDTH-1:0] r_rep_data;
  logic [T-1:0]    r_rep_tag;
  logic            w_past, w_free, w_timeout;
  logic            w_entry, w_load, w_skip, w_exit;

  assign w_timeout = (TIMEOUT != 0) && (r_timer == TW'(TIMEOUT));
  assign w_free    = ~r_rep_valid | i_rep_ready;

  // Tail may overtake the walk (acks during replay); resume from Tail, clamped at the snapshot.
  assign w_lag    = i_tail - r_rep_ptr;
  assign w_span   = r_head_snap - r_rep_ptr;
  assign w_past   = (w_lag != '0) & ~w_lag[L];
  assign w_eff    = w_past ? ((w_lag >= w_span) ? r_head_snap : i_tail) : r_rep_ptr;
  assign w_eff_nx = w_eff + 1'b1;
  assign o_rd_ptr = w_eff;

  always_comb begin
    w_state_nx = r_state;
    w_entry    = 1'b0;
    w_load     = 1'b0;
    w_skip     = 1'b0;
    w_exit     = 1'b0;
    case (r_state)
      AL_IDLE: begin
        if ((i_ack_acc & (i_ack_tag != i_tail)) | w_timeout) begin
          w_state_nx = AL_REPLAY;
          w_entry    = 1'b1;
        end
      end
      AL_REPLAY: begin
        if (w_free) begin
          if (w_eff == r_head_snap)         w_exit = 1'b1;
          else if (i_active[w_eff[L-1:0]]) w_load = 1'b1;
          else if (REPLAY_ALL != 0)        w_skip = 1'b1;
          else                             w_exit = 1'b1;
        end
        if (w_exit) w_state_nx = AL_IDLE;
      end
      default: w_state_nx = AL_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= AL_IDLE;
    else         r_state <= w_state_nx;
  end

  flopenl #(.WIDTH(T)) u_rep_ptr (
    .i_clk(i_clk), .i_reset(i_reset), .i_load(w_entry), .i_val(i_tail),
    .i_en(w_load | w_skip), .i_d(w_eff_nx), .o_q(r_rep_ptr)
  );

  flopenr #(.WIDTH(T)) u_head_snap (
    .i_clk(i_clk), .i_reset(i_reset), .i_en(w_entry), .i_d(i_head), .o_q(r_head_snap)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset | i_tail_adv | i_empty | w_exit) r_timer <= '0;
    else if (r_timer != TW'(TIMEOUT))            r_timer <= r_timer + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rep_valid <= 1'b0;
      r_rep_data  <= '0;
      r_rep_tag   <= '0;
    end else if (w_load) begin
      r_rep_valid <= 1'b1;
      r_rep_data  <= i_rd_data;
      r_rep_tag   <= w_eff;
    end else if (i_rep_ready) begin
      r_rep_valid <= 1'b0;
    end
  end

  assign o_rep_valid = r_rep_valid;
  assign o_rep_data  = r_rep_data;
  assign o_rep_tag   = r_rep_tag;
  assign o_replaying = (r_state == AL_REPLAY);

endmodule

// File: rtl/rvvi_retx_activelist.sv
// Retransmit active list: in-order insert with sequence tags, out-of-order ack retire, gap/timeout replay.
module rvvi_retx_activelist
  import rvvi_al_pkg::*;
#(
  parameter int unsigned ENTRIES_LOG2 = 3,
  parameter int unsigned WIDTH        = 792,
  parameter int unsigned TIMEOUT      = 4096,
  parameter int unsigned REPLAY_ALL   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  InsValid,
  output logic                  InsReady,
  input  logic [WIDTH-1:0]      InsData,
  output logic [ENTRIES_LOG2:0] InsTag,
  input  logic                  AckValid,
  input  logic [ENTRIES_LOG2:0] AckTag,
  output logic                  RepValid,
  input  logic                  RepReady,
  output logic [WIDTH-1:0]      RepData,
  output logic [ENTRIES_LOG2:0] RepTag,
  output logic                  Full,
  output logic                  Empty,
  output logic [ENTRIES_LOG2:0] Count,
  output logic                  StaleAck,
  output logic                  Replaying
);
  localparam int unsigned L = ENTRIES_LOG2;
  localparam int unsigned T = al_tag_width(ENTRIES_LOG2);
  localparam int unsigned D = 2**ENTRIES_LOG2;

  logic [WIDTH-1:0] r_mem [D];
  logic [D-1:0]     r_active;
  logic [T-1:0]     r_head, r_tail;
  logic             r_stale;
  logic [T-1:0]     w_count, w_ack_off, w_head_nx, w_tail_nx, w_rd_ptr;
  logic             w_full, w_empty, w_ins, w_ack_acc, w_tail_adv;
  logic [WIDTH-1:0] w_rd_data;

  assign w_count   = r_head - r_tail;
  assign w_full    = (w_count == T'(D));
  assign w_empty   = (w_count == '0);
  assign w_ins     = InsValid & ~w_full;
  assign w_ack_off = AckTag - r_tail;
  assign w_ack_acc = AckValid & (w_ack_off < w_count) & r_active[AckTag[L-1:0]];
  // An ack hitting the tail retires it in the same cycle.
  assign w_tail_adv = ~w_empty &
                      (~r_active[r_tail[L-1:0]] | (w_ack_acc & (AckTag == r_tail)));
  assign w_head_nx = r_head + 1'b1;
  assign w_tail_nx = r_tail + 1'b1;

  flopenr #(.WIDTH(T)) u_head (
    .i_clk(clk), .i_reset(reset), .i_en(w_ins), .i_d(w_head_nx), .o_q(r_head)
  );

  flopenr #(.WIDTH(T)) u_tail (
    .i_clk(clk), .i_reset(reset), .i_en(w_tail_adv), .i_d(w_tail_nx), .o_q(r_tail)
  );

  always_ff @(posedge clk) begin
    if (w_ins) r_mem[r_head[L-1:0]] <= InsData;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_active <= '0;
    end else begin
      if (w_ins)     r_active[r_head[L-1:0]] <= 1'b1;
      if (w_ack_acc) r_active[AckTag[L-1:0]] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_stale <= 1'b0;
    else       r_stale <= AckValid & ~w_ack_acc;
  end

  assign w_rd_data = r_mem[w_rd_ptr[L-1:0]];

  rvvi_al_replay_fsm #(
    .ENTRIES_LOG2(ENTRIES_LOG2),
    .WIDTH(WIDTH),
    .TIMEOUT(TIMEOUT),
    .REPLAY_ALL(REPLAY_ALL)
  ) u_fsm (
    .i_clk(clk),
    .i_reset(reset),
    .i_active(r_active),
    .i_head(r_head),
    .i_tail(r_tail),
    .i_tail_adv(w_tail_adv),
    .i_empty(w_empty),
    .i_ack_acc(w_ack_acc),
    .i_ack_tag(AckTag),
    .i_rep_ready(RepReady),
    .i_rd_data(w_rd_data),
    .o_rd_ptr(w_rd_ptr),
    .o_rep_valid(RepValid),
    .o_rep_data(RepData),
    .o_rep_tag(RepTag),
    .o_replaying(Replaying)
  );

  assign InsReady = ~w_full;
  assign InsTag   = r_head;
  assign Full     = w_full;
  assign Empty    = w_empty;
  assign Count    = w_count;
  assign StaleAck = r_stale;

endmodule

// File: tb/tb_rvvi_retx_activelist.sv
// Scoreboard bench: two lists (gap mode and replay-all) share stimulus; a monitor checks replay beats.
module tb_rvvi_retx_activelist;
  localparam int unsigned LG = 3;
  localparam int unsigned W  = 792;
  localparam int unsigned TO = 16;

  typedef struct {
    logic [LG:0]  tag;
    logic [W-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset, InsValid, AckValid, RepReady;
  logic [W-1:0]  InsData;
  logic [LG:0]   AckTag;
  logic          InsReady0, RepValid0, Full0, Empty0, StaleAck0, Replaying0;
  logic          InsReady1, RepValid1, Full1, Empty1, StaleAck1, Replaying1;
  logic [LG:0]   InsTag0, RepTag0, Count0, InsTag1, RepTag1, Count1;
  logic [W-1:0]  RepData0, RepData1;

  int            errors = 0;
  int            checks = 0;
  int            hd = 0;
  exp_t          q0[$];
  exp_t          q1[$];
  logic [W-1:0]  slot_data [16];

  always #5 clk = ~clk;

  rvvi_retx_activelist #(.ENTRIES_LOG2(LG), .WIDTH(W), .TIMEOUT(TO), .REPLAY_ALL(0)) u_dut0 (
    .clk(clk), .reset(reset), .InsValid(InsValid), .InsReady(InsReady0), .InsData(InsData),
    .InsTag(InsTag0), .AckValid(AckValid), .AckTag(AckTag), .RepValid(RepValid0),
    .RepReady(RepReady), .RepData(RepData0), .RepTag(RepTag0), .Full(Full0), .Empty(Empty0),
    .Count(Count0), .StaleAck(StaleAck0), .Replaying(Replaying0)
  );

  rvvi_retx_activelist #(.ENTRIES_LOG2(LG), .WIDTH(W), .TIMEOUT(TO), .REPLAY_ALL(1)) u_dut1 (
    .clk(clk), .reset(reset), .InsValid(InsValid), .InsReady(InsReady1), .InsData(InsData),
    .InsTag(InsTag1), .AckValid(AckValid), .AckTag(AckTag), .RepValid(RepValid1),
    .RepReady(RepReady), .RepData(RepData1), .RepTag(RepTag1), .Full(Full1), .Empty(Empty1),
    .Count(Count1), .StaleAck(StaleAck1), .Replaying(Replaying1)
  );

  function automatic logic [W-1:0] mk(input int k);
    logic [W-1:0] v;
    v = '0;
    for (int j = 0; j < 25; j++) v = {v[W-33:0], (32'(k) * 32'h01010101) ^ 32'(j)};
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic chkd(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t: got low word %h expected %h", name, $time, act[31:0], exp[31:0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic status(input int cnt, input int head);
    chk("count0", 32'(Count0), cnt);      chk("count1", 32'(Count1), cnt);
    chk("empty0", 32'(Empty0), cnt == 0); chk("empty1", 32'(Empty1), cnt == 0);
    chk("full0", 32'(Full0), cnt == 8);   chk("full1", 32'(Full1), cnt == 8);
    chk("insready0", 32'(InsReady0), cnt != 8);
    chk("insready1", 32'(InsReady1), cnt != 8);
    chk("instag0", 32'(InsTag0), head);   chk("instag1", 32'(InsTag1), head);
  endtask

  task automatic ins(input int k);
    InsValid = 1'b1;
    InsData  = mk(k);
    slot_data[hd] = mk(k);
    chk("ins_tag", 32'(InsTag0), hd);
    step();
    InsValid = 1'b0;
    hd = (hd + 1) % 16;
  endtask

  task automatic ack(input int t);
    AckValid = 1'b1;
    AckTag   = 4'(t);
    step();
    AckValid = 1'b0;
  endtask

  task automatic push_exp(input int t, input bit to0, input bit to1);
    exp_t e;
    e.tag  = 4'(t);
    e.data = slot_data[t];
    if (to0) q0.push_back(e);
    if (to1) q1.push_back(e);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((Replaying0 || Replaying1) && n < budget) begin
      step();
      n++;
    end
    chk("replay_done", 32'(Replaying0 | Replaying1), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    hd = 0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && RepValid0 && RepReady) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL rep0_unexpected t=%0t: got tag %0d expected no beat", $time, RepTag0);
      end else begin
        e = q0.pop_front();
        if (RepTag0 !== e.tag || RepData0 !== e.data) begin
          errors++;
          $display("FAIL rep0_beat t=%0t: got tag %0d data %h expected tag %0d data %h",
                   $time, RepTag0, RepData0[31:0], e.tag, e.data[31:0]);
        end
      end
    end
    if (!reset && RepValid1 && RepReady) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL rep1_unexpected t=%0t: got tag %0d expected no beat", $time, RepTag1);
      end else begin
        e = q1.pop_front();
        if (RepTag1 !== e.tag || RepData1 !== e.data) begin
          errors++;
          $display("FAIL rep1_beat t=%0t: got tag %0d data %h expected tag %0d data %h",
                   $time, RepTag1, RepData1[31:0], e.tag, e.data[31:0]);
        end
      end
    end
  end

  initial begin
    int n;
    reset = 1'b1; InsValid = 1'b0; InsData = '0; AckValid = 1'b0; AckTag = '0; RepReady = 1'b1;
    step(); step();
    reset = 1'b0;
    chk("rst_repvalid", 32'(RepValid0 | RepValid1), 0);
    chk("rst_stale", 32'(StaleAck0 | StaleAck1), 0);
    chk("rst_replaying", 32'(Replaying0 | Replaying1), 0);
    status(0, 0);

    // Fill to full; ninth insert is dropped
    for (int i = 0; i < 8; i++) ins(i);
    status(8, 8);
    InsValid = 1'b1; InsData = mk(99);
    step();
    InsValid = 1'b0;
    status(8, 8);

    // In-order acks retire one per cycle
    for (int i = 0; i < 3; i++) begin
      ack(i);
      chk("inorder_stale", 32'(StaleAck0), 0);
      chk("inorder_replaying", 32'(Replaying0), 0);
      status(7 - i, 8);
    end

    // Gap ack of tag 5: gap mode replays 3,4; replay-all replays 3,4,6,7
    push_exp(3, 1, 1); push_exp(4, 1, 1); push_exp(6, 0, 1); push_exp(7, 0, 1);
    ack(5);
    chk("gap_stale", 32'(StaleAck0), 0);
    chk("gap_enter0", 32'(Replaying0), 1);
    chk("gap_enter1", 32'(Replaying1), 1);
    wait_idle(20);
    chk("gap_q0_drained", q0.size(), 0);
    chk("gap_q1_drained", q1.size(), 0);
    ack(3); ack(4); step(); ack(6); ack(7);
    chk("drain_replaying", 32'(Replaying0 | Replaying1), 0);
    status(0, 8);

    // Timeout replay with back-pressure
    do_reset();
    status(0, 0);
    RepReady = 1'b0;
    ins(10); ins(11);
    push_exp(0, 1, 1); push_exp(1, 1, 1);
    n = 0;
    while (!RepValid0 && n < 40) begin step(); n++; end
    chk("timeout_repvalid", 32'(RepValid0), 1);
    for (int c = 0; c < 5; c++) begin
      chk("hold_valid1", 32'(RepValid1), 1);
      chk("hold_tag0", 32'(RepTag0), 0);
      chk("hold_tag1", 32'(RepTag1), 0);
      chkd("hold_data0", RepData0, mk(10));
      step();
    end
    RepReady = 1'b1;
    wait_idle(10);
    chk("to_q0_drained", q0.size(), 0);
    chk("to_q1_drained", q1.size(), 0);
    ack(0); ack(1);
    status(0, 2);

    // Stale acks: out of window, and duplicate of a retired tag
    do_reset();
    for (int i = 0; i < 4; i++) ins(20 + i);
    ack(0);
    status(3, 4);
    ack(9);
    chk("stale_out_of_range", 32'(StaleAck0), 1);
    status(3, 4);
    ack(0);
    chk("stale_duplicate", 32'(StaleAck1), 1);
    step();
    chk("stale_cleared", 32'(StaleAck0), 0);
    chk("stale_replaying", 32'(Replaying0 | Replaying1), 0);
    status(3, 4);
    ack(1); ack(2); ack(3);
    status(0, 4);

    // Tag wrap through 15 -> 0
    for (int i = 0; i < 20; i++) begin
      ins(100 + i);
      ack((4 + i) % 16);
      chk("wrap_stale", 32'(StaleAck0), 0);
    end
    chk("wrap_replaying", 32'(Replaying0 | Replaying1), 0);
    status(0, 8);

    // Reset while a replay beat is pending
    RepReady = 1'b0;
    ins(200); ins(201); ins(202);
    ack(9);
    n = 0;
    while (!RepValid0 && n < 5) begin step(); n++; end
    chk("pending_valid", 32'(RepValid0), 1);
    chk("pending_tag", 32'(RepTag0), 8);
    do_reset();
    chk("midrst_repvalid", 32'(RepValid0 | RepValid1), 0);
    chk("midrst_replaying", 32'(Replaying0 | Replaying1), 0);
    chk("midrst_stale", 32'(StaleAck0 | StaleAck1), 0);
    status(0, 0);
    RepReady = 1'b1;
    step();
    chk("final_q0", q0.size(), 0);
    chk("final_q1", q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
